// File: rtl/pe_gram_mac.sv
// pe_gram_mac: systolic Gram-array processing element.
// Forwards A/B operands east/south with one cycle of latency and accumulates
// their dot product over DIMENSION valid elements, pulsing P_valid per result.
// Optional build macro PE_GRAM_SAT_EN: saturating accumulation with a sticky
// ovf flag; when it is undefined the accumulator wraps and ovf is tied low.
module pe_gram_mac #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned ACC_WIDTH = 24,
   parameter int unsigned DIMENSION = 256,
   parameter int unsigned SIGNED    = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic                 clr,
   input  logic [WIDTH-1:0]     in_A,
   input  logic [WIDTH-1:0]     in_B,
   output logic [WIDTH-1:0]     out_A,
   output logic [WIDTH-1:0]     out_B,
   output logic                 en_o,
   output logic [ACC_WIDTH-1:0] P,
   output logic                 P_valid,
   output logic                 busy,
   output logic                 ovf
);

   localparam int unsigned PROD_W = 2 * WIDTH;
   localparam int unsigned CNT_W  = (DIMENSION > 1) ? $clog2(DIMENSION) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIMENSION - 1);

   logic [ACC_WIDTH-1:0] acc;
   logic [CNT_W-1:0]     cnt;
   logic [ACC_WIDTH-1:0] prod_ext;
   logic [ACC_WIDTH-1:0] base;
   logic [ACC_WIDTH-1:0] sum;

   // Operand product, widened to the accumulator with the selected signedness
   generate
      if (SIGNED != 0) begin : g_signed
         logic signed [PROD_W-1:0] prod;
         assign prod     = PROD_W'($signed(in_A)) * PROD_W'($signed(in_B));
         assign prod_ext = ACC_WIDTH'(prod);
      end else begin : g_unsigned
         logic [PROD_W-1:0] prod;
         assign prod     = PROD_W'(in_A) * PROD_W'(in_B);
         assign prod_ext = ACC_WIDTH'(prod);
      end
   endgenerate

   // First element of a vector starts from zero instead of the old total
   assign base = (cnt == '0) ? '0 : acc;

`ifdef PE_GRAM_SAT_EN
   localparam bit IS_SIGNED = (SIGNED != 0);

   logic [ACC_WIDTH:0] sum_g;
   logic               add_ovf;
   logic               ovf_q;

   // Guard-bit add with clamp to the representable range on overflow
   always_comb begin
      sum_g   = {(IS_SIGNED & base[ACC_WIDTH-1]), base}
              + {(IS_SIGNED & prod_ext[ACC_WIDTH-1]), prod_ext};
      add_ovf = 1'b0;
      sum     = sum_g[ACC_WIDTH-1:0];
      if (IS_SIGNED) begin
         if (sum_g[ACC_WIDTH] != sum_g[ACC_WIDTH-1]) begin
            add_ovf = 1'b1;
            sum     = sum_g[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                       : {1'b0, {(ACC_WIDTH-1){1'b1}}};
         end
      end else if (sum_g[ACC_WIDTH]) begin
         add_ovf = 1'b1;
         sum     = '1;
      end
   end

   // Sticky overflow, reloaded by the first element of each vector
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ovf_q <= 1'b0;
      end else if (clr) begin
         ovf_q <= 1'b0;
      end else if (en) begin
         ovf_q <= (cnt == '0) ? add_ovf : (ovf_q | add_ovf);
      end
   end

   assign ovf = ovf_q;
`else
   // Modulo-2^ACC_WIDTH accumulation
   assign sum = base + prod_ext;
   assign ovf = 1'b0;
`endif

   // Operand and valid forwarding to the neighbouring PEs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_A <= '0;
         out_B <= '0;
         en_o  <= 1'b0;
      end else begin
         en_o <= en;
         if (en) begin
            out_A <= in_A;
            out_B <= in_B;
         end
      end
   end

   // Accumulator, element counter and result capture
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc     <= '0;
         cnt     <= '0;
         P       <= '0;
         P_valid <= 1'b0;
      end else begin
         P_valid <= 1'b0;
         if (clr) begin
            acc <= '0;
            cnt <= '0;
         end else if (en) begin
            acc <= sum;
            if (cnt == CNT_LAST) begin
               cnt     <= '0;
               P       <= sum;
               P_valid <= 1'b1;
            end else begin
               cnt <= cnt + CNT_W'(1);
            end
         end
      end
   end

   assign busy = (cnt != '0);

endmodule

// File: tb/tb_pe_gram_mac.sv
// Bench for pe_gram_mac: three differently parameterised PEs share one input
// stream; each is checked every cycle against an arithmetic dot-product model.
module tb_pe_gram_mac;

   localparam int N = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic        clr;
   logic [7:0]  in_A;
   logic [7:0]  in_B;
   logic [7:0]  oa [N];
   logic [7:0]  ob [N];
   logic        eo [N];
   logic        pv [N];
   logic        bz [N];
   logic        ov [N];
   logic [23:0] p0;
   logic [15:0] p1;
   logic [15:0] p2;

   int n_vec = 0;
   int n_err = 0;

   // Model configuration per instance
   int m_accw [N] = '{24, 16, 16};
   int m_dim  [N] = '{4, 4, 2};
   bit m_sgn  [N] = '{1'b0, 1'b1, 1'b0};

   // Model state
   longint     m_sum [N];
   int         m_cnt [N];
   longint     m_p   [N];
   bit         m_pv  [N];
   bit         m_ovf [N];
   logic [7:0] e_oa;
   logic [7:0] e_ob;
   bit         e_eo;

`ifdef PE_GRAM_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   always #5 clk = ~clk;

   pe_gram_mac #(.WIDTH(8), .ACC_WIDTH(24), .DIMENSION(4), .SIGNED(0)) u_dut0 (
      .clk(clk), .rst(rst), .en(en), .clr(clr), .in_A(in_A), .in_B(in_B),
      .out_A(oa[0]), .out_B(ob[0]), .en_o(eo[0]), .P(p0), .P_valid(pv[0]),
      .busy(bz[0]), .ovf(ov[0]));

   pe_gram_mac #(.WIDTH(8), .ACC_WIDTH(16), .DIMENSION(4), .SIGNED(1)) u_dut1 (
      .clk(clk), .rst(rst), .en(en), .clr(clr), .in_A(in_A), .in_B(in_B),
      .out_A(oa[1]), .out_B(ob[1]), .en_o(eo[1]), .P(p1), .P_valid(pv[1]),
      .busy(bz[1]), .ovf(ov[1]));

   pe_gram_mac #(.WIDTH(8), .ACC_WIDTH(16), .DIMENSION(2), .SIGNED(0)) u_dut2 (
      .clk(clk), .rst(rst), .en(en), .clr(clr), .in_A(in_A), .in_B(in_B),
      .out_A(oa[2]), .out_B(ob[2]), .en_o(eo[2]), .P(p2), .P_valid(pv[2]),
      .busy(bz[2]), .ovf(ov[2]));

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] p_of(input int i);
      case (i)
         0:       return 64'(p0);
         1:       return 64'(p1);
         default: return 64'(p2);
      endcase
   endfunction

   task automatic model_reset();
      e_oa = '0;
      e_ob = '0;
      e_eo = 1'b0;
      for (int i = 0; i < N; i++) begin
         m_sum[i] = 0;
         m_cnt[i] = 0;
         m_p[i]   = 0;
         m_pv[i]  = 1'b0;
         m_ovf[i] = 1'b0;
      end
   endtask

   // One clock of the reference behaviour for the inputs currently applied
   task automatic model_step();
      longint a, b, mx, mn, one;
      one  = 1;
      e_eo = en;
      if (en) begin
         e_oa = in_A;
         e_ob = in_B;
      end
      for (int i = 0; i < N; i++) begin
         m_pv[i] = 1'b0;
         if (clr) begin
            m_cnt[i] = 0;
            m_sum[i] = 0;
            m_ovf[i] = 1'b0;
         end else if (en) begin
            if (m_sgn[i]) begin
               a = longint'($signed(in_A));
               b = longint'($signed(in_B));
               mx = (one <<< (m_accw[i] - 1)) - 1;
               mn = -mx - 1;
            end else begin
               a = longint'(in_A);
               b = longint'(in_B);
               mx = (one <<< m_accw[i]) - 1;
               mn = 0;
            end
            if (m_cnt[i] == 0) begin
               m_sum[i] = a * b;
               m_ovf[i] = 1'b0;
            end else begin
               m_sum[i] = m_sum[i] + a * b;
            end
            if (SAT) begin
               if (m_sum[i] > mx) begin
                  m_sum[i] = mx;
                  m_ovf[i] = 1'b1;
               end else if (m_sum[i] < mn) begin
                  m_sum[i] = mn;
                  m_ovf[i] = 1'b1;
               end
            end
            m_cnt[i]++;
            if (m_cnt[i] == m_dim[i]) begin
               m_cnt[i] = 0;
               m_p[i]   = m_sum[i] & ((one <<< m_accw[i]) - 1);
               m_pv[i]  = 1'b1;
            end
         end
      end
   endtask

   task automatic check_all();
      for (int i = 0; i < N; i++) begin
         chk($sformatf("out_A[%0d]", i), 64'(oa[i]), 64'(e_oa));
         chk($sformatf("out_B[%0d]", i), 64'(ob[i]), 64'(e_ob));
         chk($sformatf("en_o[%0d]", i), 64'(eo[i]), 64'(e_eo));
         chk($sformatf("P[%0d]", i), p_of(i), 64'(m_p[i]));
         chk($sformatf("P_valid[%0d]", i), 64'(pv[i]), 64'(m_pv[i]));
         chk($sformatf("busy[%0d]", i), 64'(bz[i]), 64'(m_cnt[i] != 0));
         chk($sformatf("ovf[%0d]", i), 64'(ov[i]), 64'(SAT & m_ovf[i]));
      end
   endtask

   task automatic step(input logic e, input logic c, input logic [7:0] a, input logic [7:0] b);
      en   = e;
      clr  = c;
      in_A = a;
      in_B = b;
      @(posedge clk);
      #1;
      model_step();
      check_all();
   endtask

   // Asynchronous reset pulse placed between clock edges
   task automatic pulse_reset();
      #2 rst = 1'b0;
      #1;
      model_reset();
      check_all();
      chk("rst_P0", p_of(0), 64'd0);
      chk("rst_busy0", 64'(bz[0]), 64'd0);
      #2 rst = 1'b1;
   endtask

   initial begin
      logic [7:0] ra, rb;
      rst  = 1'b0;
      en   = 1'b0;
      clr  = 1'b0;
      in_A = '0;
      in_B = '0;
      model_reset();
      #12;
      check_all();
      rst = 1'b1;

      // Basic vector: 1,2,3,4 times 2
      step(1'b0, 1'b1, 8'd0, 8'd0);
      for (int k = 1; k <= 4; k++) begin
         step(1'b1, 1'b0, 8'(k), 8'd2);
         if (k == 3) chk("basic_busy", 64'(bz[0]), 64'd1);
      end
      chk("basic_P", p_of(0), 64'd20);
      chk("basic_pv", 64'(pv[0]), 64'd1);
      step(1'b0, 1'b0, 8'd77, 8'd66);
      chk("basic_hold_P", p_of(0), 64'd20);
      chk("basic_pv_low", 64'(pv[0]), 64'd0);
      chk("bubble_out_A", 64'(oa[0]), 64'd4);

      // Same vector with two bubbles between elements
      step(1'b0, 1'b1, 8'd0, 8'd0);
      for (int k = 1; k <= 4; k++) begin
         step(1'b1, 1'b0, 8'(k), 8'd2);
         if (k < 4) begin
            step(1'b0, 1'b0, 8'($urandom), 8'($urandom));
            step(1'b0, 1'b0, 8'($urandom), 8'($urandom));
         end
      end
      chk("bubble_P", p_of(0), 64'd20);

      // Back-to-back vectors
      step(1'b0, 1'b1, 8'd0, 8'd0);
      for (int k = 1; k <= 4; k++) step(1'b1, 1'b0, 8'(k), 8'd2);
      chk("b2b_P1", p_of(0), 64'd20);
      for (int k = 1; k <= 4; k++) step(1'b1, 1'b0, 8'd3, 8'd3);
      chk("b2b_P2", p_of(0), 64'd36);
      chk("b2b_pv", 64'(pv[0]), 64'd1);

      // Clear mid-vector, element presented with clr is dropped
      step(1'b1, 1'b0, 8'd5, 8'd5);
      step(1'b1, 1'b0, 8'd6, 8'd6);
      step(1'b1, 1'b1, 8'd9, 8'd9);
      chk("clr_fwd", 64'(oa[0]), 64'd9);
      for (int k = 1; k <= 4; k++) step(1'b1, 1'b0, 8'd1, 8'd1);
      chk("clr_P", p_of(0), 64'd4);

      // Signed vector on the signed instance
      step(1'b0, 1'b1, 8'd0, 8'd0);
      for (int k = 1; k <= 4; k++) step(1'b1, 1'b0, 8'hFD, 8'd5);
      chk("signed_P", p_of(1), 64'h0000_0000_0000_FFC4);

      // Overflow on the 16-bit, two-element instance
      step(1'b0, 1'b1, 8'd0, 8'd0);
      step(1'b1, 1'b0, 8'd255, 8'd255);
      step(1'b1, 1'b0, 8'd255, 8'd255);
      chk("ovf_P", p_of(2), SAT ? 64'hFFFF : 64'd64514);
      chk("ovf_flag", 64'(ov[2]), SAT ? 64'd1 : 64'd0);

      // Reset mid-vector aborts it
      step(1'b1, 1'b0, 8'd7, 8'd7);
      pulse_reset();
      step(1'b0, 1'b0, 8'd0, 8'd0);
      chk("rst_no_pv", 64'(pv[0]), 64'd0);

      // Randomised traffic with occasional clears, extremes and resets
      for (int t = 0; t < 800; t++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         if ($urandom_range(0, 3) == 0) ra = ($urandom_range(0, 1) != 0) ? 8'h80 : 8'hFF;
         if ($urandom_range(0, 3) == 0) rb = ($urandom_range(0, 1) != 0) ? 8'h80 : 8'h7F;
         step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 39) == 0), ra, rb);
         if (t % 250 == 249) pulse_reset();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/pe_gram_mac.md
# pe_gram_mac

Parametrised successor processing element for the systolic Gram-matrix array. Forwards operand streams A and B to the neighbouring PE with one-cycle latency while accumulating their dot product over a fixed vector length. Adds a wide accumulator, signed mode, bubble tolerance, synchronous clear and a one-cycle result-valid pulse. Sits in each cell of the Gram array, feeding the result-collection chain.

## Interface
- WIDTH, 8: operand width of in_A/in_B.
- ACC_WIDTH, 24: accumulator and result width; must be >= 2*WIDTH.
- DIMENSION, 256: elements per dot product; >= 1.
- SIGNED, 0: 1 means operands and products are two's complement; 0 means unsigned.
- clk  input  1  clock; all logic on its rising edge.
- rst  input  1  asynchronous active-low reset.
- en  input  1  operand valid; low means bubble.
- clr  input  1  synchronous clear of accumulation state.
- in_A  input  WIDTH  operand from the west neighbour.
- in_B  input  WIDTH  operand from the north neighbour.
- out_A  output  WIDTH  registered in_A to the east neighbour.
- out_B  output  WIDTH  registered in_B to the south neighbour.
- en_o  output  1  registered en to the neighbours.
- P  output  ACC_WIDTH  last completed dot product; held until the next completion.
- P_valid  output  1  one-cycle pulse on each P update.
- busy  output  1  high while a vector is partially accumulated (cnt != 0).
- ovf  output  1  sticky overflow flag for the current/last vector.

## Operation
- Reset (rst low, asynchronous) clears every register to 0: out_A, out_B, en_o, P, P_valid, busy, ovf, internal acc and cnt.
- Forwarding: en_o <= en every cycle. out_A/out_B load in_A/in_B only when en=1; otherwise they hold. clr does not affect forwarding.
- Product: in_A*in_B, 2*WIDTH bits, signed when SIGNED=1. It is sign- or zero-extended to ACC_WIDTH.
- Element counter cnt runs 0..DIMENSION-1. It advances only on en=1 and wraps to 0 after DIMENSION-1.
- On en=1 and cnt==0: acc <= product.
- On en=1 and cnt>0: acc <= acc + product.
- On en=1 and cnt==DIMENSION-1: P <= final sum (acc + product, or product alone if DIMENSION=1), P_valid <= 1, cnt <= 0.
- P_valid is 0 in every other cycle.
- en=0 (bubble): acc, cnt and P hold. A vector may span any number of bubbles.
- clr=1: cnt <= 0, acc <= 0, ovf <= 0, P_valid <= 0; P holds. clr has priority over en; an element presented with clr is dropped from accumulation but still forwarded.
- busy = (cnt != 0), combinational from cnt.
- Back-to-back vectors need no idle cycle. The element after the last one starts a new vector.

## Timing
- Forward latency: 1 cycle, from in_A/in_B/en to out_A/out_B/en_o.
- Result latency: P and P_valid are valid in the cycle after the edge that sampled the final element.
- Throughput: 1 element per cycle; 1 result per DIMENSION accepted elements.
- Reset asserted mid-vector aborts the vector; no P_valid is produced for it.

## Configuration
- PE_GRAM_SAT_EN defined:
  - The accumulation add is computed with one guard bit.
  - On overflow the result clamps to the ACC_WIDTH maximum: all-ones when unsigned, max positive when signed. Signed underflow clamps to min negative.
  - ovf is set and stays high until clr, reset, or the first element of the next vector, which reloads ovf from that element's add.
- PE_GRAM_SAT_EN undefined:
  - The accumulator wraps modulo 2^ACC_WIDTH.
  - ovf is tied to 0.

## Test plan
- Basic: DIMENSION=4, SIGNED=0, A=1,2,3,4 with B=2, en contiguous -> P=20 with one P_valid pulse the cycle after the 4th element; out_A/en_o follow the inputs by 1 cycle; busy high for 3 cycles.
- Bubbles: same vector with en low for 2 cycles between each element -> P=20, a single P_valid pulse; out_A holds during bubbles.
- Back-to-back: vector 1 as in the basic case, then immediately A=3, B=3 four times -> P=20 then P=36, pulses exactly 4 cycles apart; P holds 20 in between.
- Clear and reset: clr after 2 elements, then a full vector of A=1, B=1 -> P=4. Separately, rst pulsed low mid-vector -> all outputs 0 immediately, no P_valid.
- Signed: SIGNED=1, DIMENSION=4, A=-3, B=5 four times -> P=-60 (ACC_WIDTH=24: 24'hFFFFC4).
- Overflow: WIDTH=8, ACC_WIDTH=16, DIMENSION=2, SIGNED=0, A=B=255 twice -> with PE_GRAM_SAT_EN: P=16'hFFFF, ovf=1. Without it: P=64514, ovf=0.
